scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 197 +++++++++++++++++++
 tb/tb_scan_decoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// One-hot output decoder with two ways of choosing the active line:
//   - direct : out follows sel with one cycle of latency
//   - scan   : out walks upward from a start index, holding each index for
//              dwell+1 cycles, either forever or for exactly one full pass
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   global enable; low returns the block to IDLE
//   mode      in   0 = direct decode, 1 = scan
//   sel       in   decode index (direct) / start index (scan)
//   dwell     in   extra hold cycles per index in scan
//   one_shot  in   1 = stop after a single full pass (sampled at start)
//   start     in   single-cycle pulse that begins a scan
//   stop      in   single-cycle pulse that aborts a scan
//   out       out  registered one-hot or all-zero decode
//   cur_sel   out  index currently driven on out
//   busy      out  high while scanning
//   wrap      out  one-cycle pulse when the scan index rolls over to 0
//   done      out  one-cycle pulse in the first IDLE cycle after a
//                  one-shot pass completes
//
// State table
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | out = 0, cur_sel = 0, waiting for en
//   ST_DIRECT | out = 1 << sel of the previous cycle
//   ST_SCAN   | walking the index, holding each for dwell_r+1 cycles
// -----------------------------------------------------------------------------
module scan_decoder #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  one_shot,
    input  logic                  start,
    input  logic                  stop,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy,
    output logic                  wrap,
    output logic                  done
);

    localparam int OUT_W = 2**SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [OUT_W-1:0]     out_q,       out_d;
    logic [SEL_W-1:0]     idx_q,       idx_d;
    logic                 busy_q,      busy_d;
    logic                 wrap_q,      wrap_d;
    logic                 done_q,      done_d;
    logic [DWELL_W-1:0]   dwell_r_q,   dwell_r_d;
    logic [DWELL_W-1:0]   cnt_q,       cnt_d;
    logic [SEL_W-1:0]     start_idx_q, start_idx_d;
    logic                 one_shot_q,  one_shot_d;

    logic [SEL_W-1:0]     idx_inc;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Natural SEL_W-bit wrap gives the modulo-2**SEL_W increment.
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        dwell_r_d   = dwell_r_q;
        cnt_d       = cnt_q;
        start_idx_d = start_idx_q;
        one_shot_d  = one_shot_q;

        case (state_q)
            ST_IDLE: begin
                out_d  = '0;
                idx_d  = '0;
                busy_d = 1'b0;
                if (en && !mode) begin
                    state_d = ST_DIRECT;
                    idx_d   = sel;
                    out_d   = onehot(sel);
                end else if (en && mode && start && !stop) begin
                    // Everything the scan depends on is captured here so
                    // later changes on sel/dwell/one_shot are ignored.
                    state_d     = ST_SCAN;
                    idx_d       = sel;
                    out_d       = onehot(sel);
                    busy_d      = 1'b1;
                    start_idx_d = sel;
                    dwell_r_d   = dwell;
                    cnt_d       = '0;
                    one_shot_d  = one_shot;
                end
            end

            ST_DIRECT: begin
                if (!en || mode) begin
                    state_d = ST_IDLE;
                    out_d   = '0;
                    idx_d   = '0;
                end else begin
                    idx_d = sel;
                    out_d = onehot(sel);
                end
            end

            ST_SCAN: begin
                if (stop || !en || !mode) begin
                    state_d = ST_IDLE;
                    out_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == dwell_r_q) begin
                    cnt_d = '0;
                    if (one_shot_q && (idx_inc == start_idx_q)) begin
                        // Pass complete; this check comes before the wrap
                        // check so a pass starting at 0 ends without wrap.
                        state_d = ST_IDLE;
                        out_d   = '0;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_inc;
                        out_d  = onehot(idx_inc);
                        wrap_d = (idx_inc == '0);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                out_d   = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            dwell_r_q   <= '0;
            cnt_q       <= '0;
            start_idx_q <= '0;
            one_shot_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            dwell_r_q   <= dwell_r_d;
            cnt_q       <= cnt_d;
            start_idx_q <= start_idx_d;
            one_shot_q  <= one_shot_d;
        end
    end

    assign out     = out_q;
    assign cur_sel = idx_q;
    assign busy    = busy_q;
    assign wrap    = wrap_q;
    assign done    = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//
// Four decoder instances share one stimulus stream:
//   u0 SEL_W=4 DWELL_W=8, u1 SEL_W=2 DWELL_W=8,
//   u2 SEL_W=5 DWELL_W=8, u3 SEL_W=4 DWELL_W=3
// Each instance has its own behavioural model. In scan the model tracks only
// the elapsed scan cycle t; the driven index is start + t/(dwell+1) mod N.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, mode = 1'b0, one_shot = 1'b0, start = 1'b0, stop = 1'b0;
    logic [4:0] sel = '0;
    logic [7:0] dwell = '0;

    always #5 clk = ~clk;

    logic [15:0] out0;  logic [3:0] cur0;  logic busy0, wrap0, done0;
    logic [3:0]  out1;  logic [1:0] cur1;  logic busy1, wrap1, done1;
    logic [31:0] out2;  logic [4:0] cur2;  logic busy2, wrap2, done2;
    logic [15:0] out3;  logic [3:0] cur3;  logic busy3, wrap3, done3;

    scan_decoder #(.SEL_W(4), .DWELL_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[3:0]), .dwell(dwell),
        .one_shot(one_shot), .start(start), .stop(stop),
        .out(out0), .cur_sel(cur0), .busy(busy0), .wrap(wrap0), .done(done0));
    scan_decoder #(.SEL_W(2), .DWELL_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .dwell(dwell),
        .one_shot(one_shot), .start(start), .stop(stop),
        .out(out1), .cur_sel(cur1), .busy(busy1), .wrap(wrap1), .done(done1));
    scan_decoder #(.SEL_W(5), .DWELL_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
        .one_shot(one_shot), .start(start), .stop(stop),
        .out(out2), .cur_sel(cur2), .busy(busy2), .wrap(wrap2), .done(done2));
    scan_decoder #(.SEL_W(4), .DWELL_W(3)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[3:0]), .dwell(dwell[2:0]),
        .one_shot(one_shot), .start(start), .stop(stop),
        .out(out3), .cur_sel(cur3), .busy(busy3), .wrap(wrap3), .done(done3));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sw(input int i);
        case (i)
            1:       return 2;
            2:       return 5;
            default: return 4;
        endcase
    endfunction

    function automatic int dmask(input int i);
        return (i == 3) ? 7 : 255;
    endfunction

    // ---------------- behavioural model ----------------
    localparam int M_IDLE   = 0;
    localparam int M_DIRECT = 1;
    localparam int M_SCAN   = 2;

    int m_st  [4];
    int m_sel [4];
    int m_t   [4];
    int m_s0  [4];
    int m_d   [4];
    bit m_os  [4];
    bit m_done[4];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_st[i]   <= M_IDLE;
                m_sel[i]  <= 0;
                m_t[i]    <= 0;
                m_s0[i]   <= 0;
                m_d[i]    <= 0;
                m_os[i]   <= 1'b0;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                case (m_st[i])
                    M_IDLE: begin
                        if (en && !mode) begin
                            m_st[i]  <= M_DIRECT;
                            m_sel[i] <= int'(sel) % (1 << sw(i));
                        end else if (en && mode && start && !stop) begin
                            m_st[i] <= M_SCAN;
                            m_t[i]  <= 0;
                            m_s0[i] <= int'(sel) % (1 << sw(i));
                            m_d[i]  <= int'(dwell) & dmask(i);
                            m_os[i] <= one_shot;
                        end
                    end
                    M_DIRECT: begin
                        if (!en || mode) m_st[i] <= M_IDLE;
                        else             m_sel[i] <= int'(sel) % (1 << sw(i));
                    end
                    default: begin
                        if (stop || !en || !mode) begin
                            m_st[i] <= M_IDLE;
                        end else if (m_os[i] && (m_t[i] + 1 == (1 << sw(i)) * (m_d[i] + 1))) begin
                            m_st[i]   <= M_IDLE;
                            m_done[i] <= 1'b1;
                        end else begin
                            m_t[i] <= m_t[i] + 1;
                        end
                    end
                endcase
            end
        end
    end

    // {out[31:0], cur_sel[4:0], busy, wrap, done}
    function automatic logic [39:0] model_vec(input int i);
        int         idx;
        logic [31:0] o;
        logic [4:0]  c;
        logic        b, w, d;
        o = '0; c = '0; b = 1'b0; w = 1'b0; d = 1'b0;
        case (m_st[i])
            M_IDLE: d = m_done[i];
            M_DIRECT: begin
                o = 32'd1 << m_sel[i];
                c = 5'(m_sel[i]);
            end
            default: begin
                idx = (m_s0[i] + m_t[i] / (m_d[i] + 1)) % (1 << sw(i));
                o   = 32'd1 << idx;
                c   = 5'(idx);
                b   = 1'b1;
                w   = (m_t[i] > 0) && (m_t[i] % (m_d[i] + 1) == 0) && (idx == 0);
            end
        endcase
        return {o, c, b, w, d};
    endfunction

    function automatic logic [39:0] dut_vec(input int i);
        case (i)
            0:       return {16'h0, out0, 1'b0, cur0, busy0, wrap0, done0};
            1:       return {28'h0, out1, 3'b0, cur1, busy1, wrap1, done1};
            2:       return {out2, cur2, busy2, wrap2, done2};
            default: return {16'h0, out3, 1'b0, cur3, busy3, wrap3, done3};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            chk($sformatf("cycle_u%0d", i), 64'(dut_vec(i)), 64'(model_vec(i)));
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    int nb0, nb1, nb2, nb3, nw0, nw2, nd0, dc0;

    initial begin
        // reset
        step(2);
        chk("rst_out0", 64'(out0), 64'(0));
        chk("rst_busy0", 64'(busy0), 64'(0));
        #3 rst_n = 1'b1;
        step(2);
        chk("idle_after_rst", 64'(out0), 64'(0));

        // direct sweep
        en = 1'b1; mode = 1'b0;
        for (int k = 0; k < 32; k++) begin
            sel = 5'(k);
            step(1);
            chk("direct_u0", 64'(out0), 64'(16'h1) << (k % 16));
            chk("direct_cur0", 64'(cur0), 64'(k % 16));
            chk("direct_u1", 64'(out1), 64'(4'h1) << (k % 4));
            chk("direct_u2", 64'(out2), 64'(32'h1) << k);
        end
        mode = 1'b1;
        step(1);
        chk("direct_exit_out0", 64'(out0), 64'(0));
        en = 1'b0; mode = 1'b0;
        step(1);

        // scan with dwell=2 from 14
        en = 1'b1; mode = 1'b1; sel = 5'd14; dwell = 8'd2; one_shot = 1'b0;
        pulse_start();
        chk("scan_first", 64'(out0), 64'(16'h4000));
        chk("scan_busy", 64'(busy0), 64'(1));
        step(3);
        chk("scan_15", 64'(out0), 64'(16'h8000));
        step(3);
        chk("scan_wrap_out", 64'(out0), 64'(16'h0001));
        chk("scan_wrap", 64'(wrap0), 64'(1));
        step(1);
        chk("scan_wrap_once", 64'(wrap0), 64'(0));
        sel = 5'd5; dwell = 8'd0;
        step(1);
        chk("scan_ignore_sel", 64'(out0), 64'(16'h0001));
        step(1);
        chk("scan_idx1", 64'(out0), 64'(16'h0002));

        // abort: start+stop together, then a lone stop
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("abort_busy", 64'(busy0), 64'(0));
        chk("abort_out", 64'(out0), 64'(0));
        chk("abort_done", 64'(done0), 64'(0));
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("abort_stay_idle", 64'(busy0), 64'(0));
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("idle_stop_prio", 64'(busy0), 64'(0));

        // one-shot from 3, dwell 0
        sel = 5'd3; dwell = 8'd0; one_shot = 1'b1;
        pulse_start();
        nb0 = 0; nb1 = 0; nb2 = 0; nw0 = 0; nd0 = 0; dc0 = -1;
        for (int c = 0; c < 40; c++) begin
            if (busy0) begin
                chk("oneshot_seq", 64'(out0), 64'(16'h1) << ((3 + nb0) % 16));
                nb0++;
            end
            if (busy1) nb1++;
            if (busy2) nb2++;
            if (wrap0) nw0++;
            if (done0) begin nd0++; dc0 = c; end
            step(1);
        end
        chk("oneshot_busy0", 64'(nb0), 64'(16));
        chk("oneshot_busy1", 64'(nb1), 64'(4));
        chk("oneshot_busy2", 64'(nb2), 64'(32));
        chk("oneshot_wrap0", 64'(nw0), 64'(1));
        chk("oneshot_done0", 64'(nd0), 64'(1));
        chk("oneshot_done_at", 64'(dc0), 64'(16));
        chk("oneshot_out_end", 64'(out0), 64'(0));

        // one-shot from 0, dwell 1: no wrap
        sel = 5'd0; dwell = 8'd1; one_shot = 1'b1;
        pulse_start();
        nb0 = 0; nb2 = 0; nw0 = 0; nw2 = 0; nd0 = 0;
        for (int c = 0; c < 70; c++) begin
            if (busy0) nb0++;
            if (busy2) nb2++;
            if (wrap0) nw0++;
            if (wrap2) nw2++;
            if (done0) nd0++;
            step(1);
        end
        chk("os0_busy0", 64'(nb0), 64'(32));
        chk("os0_busy2", 64'(nb2), 64'(64));
        chk("os0_wrap0", 64'(nw0), 64'(0));
        chk("os0_wrap2", 64'(nw2), 64'(0));
        chk("os0_done0", 64'(nd0), 64'(1));

        // dwell=7 (maximum for u3)
        sel = 5'd0; dwell = 8'd7; one_shot = 1'b0;
        pulse_start();
        nb3 = 0;
        for (int j = 0; j < 8; j++) begin
            if (out3 == 16'h0001) nb3++;
            step(1);
        end
        chk("dwell7_hold_u3", 64'(nb3), 64'(8));
        chk("dwell7_next_u3", 64'(out3), 64'(16'h0002));
        chk("dwell7_next_u0", 64'(out0), 64'(16'h0002));
        stop = 1'b1;
        step(1);
        stop = 1'b0;

        // asynchronous reset mid-scan
        sel = 5'd5; dwell = 8'd3; one_shot = 1'b0;
        pulse_start();
        step(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out0", 64'(out0), 64'(0));
        chk("arst_busy0", 64'(busy0), 64'(0));
        chk("arst_out2", 64'(out2), 64'(0));
        #3 rst_n = 1'b1;
        step(3);
        chk("arst_stay_idle", 64'(busy0), 64'(0));
        chk("arst_out_idle", 64'(out0), 64'(0));
        pulse_start();
        chk("arst_restart_busy", 64'(busy0), 64'(1));
        chk("arst_restart_out", 64'(out0), 64'(16'h0020));
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
